// File: rtl/avcmd_pkg.sv
// Command-beat definitions shared by both halves of the AVMM/AVST command bridge.
// Build option: AVCMD_BYTE_ENABLE_EN adds per-byte enables to the control field.
package avcmd_pkg;

    localparam int AVCMD_ADDR_WIDTH = 48;
    localparam int AVCMD_DATA_WIDTH = 512;
    localparam int CTRL_RD_BIT      = 0;

    // Control field: bit 0 selects read/write; byte enables sit above it when enabled.
    function automatic int ctrl_width(input int data_width);
`ifdef AVCMD_BYTE_ENABLE_EN
        return 1 + data_width / 8;
`else
        return 1;
`endif
    endfunction

    localparam int AVCMD_CTRL_WIDTH = ctrl_width(AVCMD_DATA_WIDTH);

    typedef struct packed {
        logic [AVCMD_ADDR_WIDTH-1:0] addr;
        logic [AVCMD_DATA_WIDTH-1:0] write_data;
        logic [AVCMD_CTRL_WIDTH-1:0] control;
    } t_avcmd;

endpackage

// File: rtl/avcmd_rsp_fifo.sv
// Synchronous response FIFO: binary pointers with an extra wrap bit, head readable
// combinationally the cycle after a push.
module avcmd_rsp_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/avcmd_to_avmm_host.sv
// Replays packed command beats as single-beat Avalon-MM transactions; read data returns
// through a credit-protected response FIFO. Build option: AVCMD_BYTE_ENABLE_EN.
module avcmd_to_avmm_host
    import avcmd_pkg::*;
#(
    parameter int  AVMM_ADDR_WIDTH = 48,
    parameter int  AVMM_DATA_WIDTH = 512,
    parameter int  RSP_FIFO_DEPTH  = 16,
    localparam int CTRL_WIDTH      = ctrl_width(AVMM_DATA_WIDTH),
    localparam int CMD_WIDTH       = AVMM_ADDR_WIDTH + AVMM_DATA_WIDTH + CTRL_WIDTH,
    localparam int BE_WIDTH        = AVMM_DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CMD_WIDTH-1:0]       avst_avcmd_data,
    input  logic                       avst_avcmd_valid,
    output logic                       avst_avcmd_ready,
    output logic [AVMM_ADDR_WIDTH-1:0] avmm_address,
    output logic [AVMM_DATA_WIDTH-1:0] avmm_writedata,
    output logic [BE_WIDTH-1:0]        avmm_byteenable,
    output logic                       avmm_burstcount,
    output logic                       avmm_read,
    output logic                       avmm_write,
    input  logic                       avmm_waitrequest,
    input  logic [AVMM_DATA_WIDTH-1:0] avmm_readdata,
    input  logic                       avmm_readdatavalid,
    output logic [AVMM_DATA_WIDTH-1:0] avst_rd_rsp_data,
    output logic                       avst_rd_rsp_valid,
    input  logic                       avst_rd_rsp_ready,
    output logic                       rsp_overflow
);

    localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [AVMM_ADDR_WIDTH-1:0] addr;
        logic [AVMM_DATA_WIDTH-1:0] write_data;
        logic [CTRL_WIDTH-1:0]      control;
    } t_cmd;

    t_cmd          hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          rsp_overflow_q;

    logic is_read;
    logic credit_ok;
    logic issue;
    logic rd_issue;
    logic accept;
    logic rsp_pop;
    logic fifo_full;
    logic fifo_empty;

    // A read only goes out while the FIFO is guaranteed a free slot for its response.
    assign is_read   = hold_q.control[CTRL_RD_BIT];
    assign credit_ok = (credits_q < CW'(RSP_FIFO_DEPTH));
    assign avmm_read  = hold_valid_q & is_read & credit_ok;
    assign avmm_write = hold_valid_q & ~is_read;
    assign issue      = (avmm_read | avmm_write) & ~avmm_waitrequest;
    assign rd_issue   = avmm_read & ~avmm_waitrequest;

    assign avst_avcmd_ready = ~reset & (~hold_valid_q | issue);
    assign accept           = avst_avcmd_valid & avst_avcmd_ready;

    assign avmm_address    = hold_q.addr;
    assign avmm_writedata  = hold_q.write_data;
    assign avmm_burstcount = 1'b1;
`ifdef AVCMD_BYTE_ENABLE_EN
    assign avmm_byteenable = hold_q.control[BE_WIDTH:1];
`else
    assign avmm_byteenable = '1;
`endif

    assign avst_rd_rsp_valid = ~fifo_empty;
    assign rsp_pop           = avst_rd_rsp_valid & avst_rd_rsp_ready;
    assign rsp_overflow      = rsp_overflow_q;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (accept) begin
            hold_d       = t_cmd'(avst_avcmd_data);
            hold_valid_d = 1'b1;
        end else if (issue) begin
            hold_valid_d = 1'b0;
        end

        credits_d = credits_q;
        case ({rd_issue, rsp_pop})
            2'b10:   credits_d = credits_q + CW'(1);
            2'b01:   credits_d = credits_q - CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q         <= '0;
            hold_valid_q   <= 1'b0;
            credits_q      <= '0;
            rsp_overflow_q <= 1'b0;
        end else begin
            hold_q         <= hold_d;
            hold_valid_q   <= hold_valid_d;
            credits_q      <= credits_d;
            rsp_overflow_q <= rsp_overflow_q | (avmm_readdatavalid & fifo_full);
        end
    end

    avcmd_rsp_fifo #(
        .WIDTH (AVMM_DATA_WIDTH),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (avmm_readdatavalid),
        .push_data_i (avmm_readdata),
        .pop_i       (rsp_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (avst_rd_rsp_data)
    );

endmodule
